// File: rtl/uart_tx_feeder.sv
// Transmit feeder for the MiniUART: buffers CPU bytes in a FIFO and drains
// them over WISHBONE, polling LSR[5] before each TX data register write.
module uart_tx_feeder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int GUARD      = 4
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  push,
  input  logic [7:0]            push_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovf,
  output logic                  busy,
  output logic [4:0]            M_ADD_O,
  output logic [31:0]           M_DAT_O,
  input  logic [31:0]           M_DAT_I,
  output logic                  M_STB_O,
  output logic                  M_WE_O,
  input  logic                  M_ACK_I
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int GW    = $clog2(GUARD);
  localparam logic [GW-1:0]         GUARD_LOAD = GW'(GUARD - 1);
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1'b1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1'b1);
  localparam logic [GW-1:0]         GUARD_ONE  = GW'(1'b1);
  localparam logic [4:0]            ADDR_LSR   = 5'b01000;
  localparam logic [4:0]            ADDR_TXD   = 5'b00100;

  typedef enum logic [1:0] {ST_IDLE, ST_POLL, ST_WRITE, ST_GUARD} state_t;

  state_t                  state_r, state_next_s;
  logic [7:0]              mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_r, rd_ptr_r;
  logic [DEPTH_LOG2:0]     count_r;
  logic                    ovf_r;
  logic [GW-1:0]           guard_cnt_r;
  logic                    full_s, empty_s, push_ok_s, pop_s;
  logic                    stb_r, we_r, stb_next_s, we_next_s;
  logic [4:0]              add_r, add_next_s;
  logic [31:0]             dat_r, dat_next_s;
  logic                    dat_i_unused_s;

  assign full_s         = (count_r == DEPTH_CNT);
  assign empty_s        = (count_r == '0);
  assign push_ok_s      = push && !full_s;
  assign pop_s          = (state_r == ST_WRITE) && M_ACK_I;
  assign dat_i_unused_s = ^{M_DAT_I[31:6], M_DAT_I[4:0]};

  assign full    = full_s;
  assign empty   = empty_s;
  assign count   = count_r;
  assign ovf     = ovf_r;
  assign busy    = (state_r != ST_IDLE) || !empty_s;
  assign M_STB_O = stb_r;
  assign M_WE_O  = we_r;
  assign M_ADD_O = add_r;
  assign M_DAT_O = dat_r;

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge CLK_I) begin
    if (push_ok_s && !RST_I) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      ovf_r    <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)     rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (push && full_s) ovf_r <= 1'b1;
    end
  end

  // Master FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  if (!empty_s) state_next_s = ST_POLL;  else state_next_s = ST_IDLE;
      ST_POLL:  if (M_ACK_I && M_DAT_I[5]) state_next_s = ST_WRITE; else state_next_s = ST_POLL;
      ST_WRITE: if (M_ACK_I) state_next_s = ST_GUARD; else state_next_s = ST_WRITE;
      ST_GUARD: if (guard_cnt_r == '0) state_next_s = ST_IDLE; else state_next_s = ST_GUARD;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Bus outputs decoded from the upcoming state so they register in step with it;
  // the head cannot move before the WRITE ack, so sampling it here is safe
  always_comb begin
    stb_next_s = 1'b0;
    we_next_s  = 1'b0;
    add_next_s = 5'b00000;
    dat_next_s = 32'h0000_0000;
    case (state_next_s)
      ST_POLL: begin
        stb_next_s = 1'b1;
        add_next_s = ADDR_LSR;
      end
      ST_WRITE: begin
        stb_next_s = 1'b1;
        we_next_s  = 1'b1;
        add_next_s = ADDR_TXD;
        dat_next_s = {24'h00_0000, mem_r[rd_ptr_r]};
      end
      default: begin
        stb_next_s = 1'b0;
      end
    endcase
  end

  // State, guard counter and registered bus outputs
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_r     <= ST_IDLE;
      guard_cnt_r <= '0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      add_r       <= 5'b00000;
      dat_r       <= 32'h0000_0000;
    end else begin
      state_r <= state_next_s;
      stb_r   <= stb_next_s;
      we_r    <= we_next_s;
      add_r   <= add_next_s;
      dat_r   <= dat_next_s;
      if (pop_s) begin
        guard_cnt_r <= GUARD_LOAD;
      end else if (state_r == ST_GUARD && guard_cnt_r != '0) begin
        guard_cnt_r <= guard_cnt_r - GUARD_ONE;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple MiniUART bus responder.
module tb_uart_tx_feeder;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        push = 1'b0;
  logic [7:0]  push_data = 8'h00;
  logic        full, empty, ovf, busy;
  logic [4:0]  count;
  logic [4:0]  M_ADD_O;
  logic [31:0] M_DAT_O, M_DAT_I;
  logic        M_STB_O, M_WE_O, M_ACK_I;
  logic        ack_en = 1'b0;
  logic        lsr_idle = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] wq[$];
  int         wt[$];

  uart_tx_feeder dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .push(push), .push_data(push_data),
    .full(full), .empty(empty), .count(count), .ovf(ovf), .busy(busy),
    .M_ADD_O(M_ADD_O), .M_DAT_O(M_DAT_O), .M_DAT_I(M_DAT_I),
    .M_STB_O(M_STB_O), .M_WE_O(M_WE_O), .M_ACK_I(M_ACK_I)
  );

  assign M_ACK_I = ack_en & M_STB_O;
  assign M_DAT_I = lsr_idle ? 32'h0000_0020 : 32'h0000_0000;

  always #5 CLK_I = ~CLK_I;

  always @(posedge CLK_I) cyc++;

  // record every acknowledged TX write, sampled mid-cycle
  always @(negedge CLK_I) begin
    if (!RST_I && M_STB_O && M_WE_O && M_ACK_I) begin
      wq.push_back(M_DAT_O[7:0]);
      wt.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    push = 1'b1;
    push_data = b;
    tick();
    push = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    check_val("idle", busy, 0);
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget && wq.size() < n; i++) tick();
    check_val("nwrites", wq.size(), n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_count"}, count, 0);
    check_val({tag, "_empty"}, empty, 1);
    check_val({tag, "_full"}, full, 0);
    check_val({tag, "_ovf"}, ovf, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_bus"}, {M_STB_O, M_WE_O, M_ADD_O}, 0);
    check_val({tag, "_dat"}, M_DAT_O, 0);
  endtask

  initial begin
    tick();
    tick();
    RST_I = 1'b0;
    check_reset_outputs("rst0");

    // single byte, UART idle
    ack_en = 1'b1;
    push_byte(8'h41);
    check_val("s_cnt1", count, 1);
    tick();
    check_val("s_poll", {M_STB_O, M_WE_O, M_ADD_O}, {2'b10, 5'h08});
    tick();
    check_val("s_write", {M_STB_O, M_WE_O, M_ADD_O}, {2'b11, 5'h04});
    check_val("s_dat", M_DAT_O, 32'h0000_0041);
    tick();
    check_val("s_cnt0", count, 0);
    check_val("s_empty", empty, 1);
    check_val("s_stb_g", M_STB_O, 0);
    tick(); tick(); tick();
    check_val("s_guard_busy", busy, 1);
    tick();
    check_val("s_idle_busy", busy, 0);
    check_val("s_nwr", wq.size(), 1);
    check_val("s_byte", wq[0], 8'h41);
    wq.delete(); wt.delete();

    // transmitter busy for 20 polls
    lsr_idle = 1'b0;
    push_byte(8'h42);
    tick();
    for (int i = 0; i < 20; i++) begin
      check_val("b_poll", {M_STB_O, M_WE_O}, 2'b10);
      tick();
    end
    check_val("b_nowr", wq.size(), 0);
    lsr_idle = 1'b1;
    tick();
    check_val("b_write", {M_STB_O, M_WE_O}, 2'b11);
    check_val("b_dat", M_DAT_O, 32'h0000_0042);
    wait_writes(1, 20);
    wait_idle(20);
    wq.delete(); wt.delete();

    // burst of 16, order and spacing
    ack_en = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    check_val("u_full", full, 1);
    check_val("u_cnt", count, 16);
    check_val("u_ovf", ovf, 0);
    ack_en = 1'b1;
    wait_writes(16, 300);
    for (int i = 0; i < 16 && i < wq.size(); i++) begin
      check_val("u_order", wq[i], 8'h10 + 8'(i));
      if (i > 0) check_val("u_gap_ge7", (wt[i] - wt[i-1]) >= 7, 1);
    end
    wait_idle(30);
    check_val("u_ovf_end", ovf, 0);
    wq.delete(); wt.delete();

    // overflow: 17 pushes with no drain
    ack_en = 1'b0;
    for (int i = 0; i < 17; i++) push_byte(8'h60 + 8'(i));
    check_val("o_cnt", count, 16);
    check_val("o_full", full, 1);
    check_val("o_ovf", ovf, 1);
    ack_en = 1'b1;
    wait_writes(16, 300);
    wait_idle(30);
    for (int i = 0; i < 16 && i < wq.size(); i++) check_val("o_order", wq[i], 8'h60 + 8'(i));
    check_val("o_nwr", wq.size(), 16);
    check_val("o_ovf_sticky", ovf, 1);
    check_val("o_cnt0", count, 0);
    wq.delete(); wt.delete();

    // simultaneous push and pop at count=3
    ack_en = 1'b0;
    push_byte(8'hA0);
    push_byte(8'hA1);
    push_byte(8'hA2);
    check_val("p_cnt3", count, 3);
    ack_en = 1'b1;
    tick();
    check_val("p_write", {M_STB_O, M_WE_O}, 2'b11);
    check_val("p_dat", M_DAT_O, 32'h0000_00A0);
    push_byte(8'h55);
    check_val("p_cnt_same", count, 3);
    wait_writes(4, 100);
    wait_idle(30);
    if (wq.size() == 4) begin
      check_val("p_o1", wq[1], 8'hA1);
      check_val("p_o2", wq[2], 8'hA2);
      check_val("p_o3", wq[3], 8'h55);
    end
    wq.delete(); wt.delete();

    // reset mid-WRITE with push held
    ack_en = 1'b0;
    push_byte(8'hB0);
    tick();
    ack_en = 1'b1;
    tick();
    ack_en = 1'b0;
    check_val("r_inwrite", {M_STB_O, M_WE_O}, 2'b11);
    RST_I = 1'b1;
    push = 1'b1;
    push_data = 8'hEE;
    tick();
    tick();
    RST_I = 1'b0;
    push = 1'b0;
    check_reset_outputs("rst1");
    ack_en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check_val("r_nostb", M_STB_O, 0);
    check_val("r_nowr", wq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
